// File: rtl/trng_pkg.sv
// Shared constants for the TRNG post-processing slice.
package trng_pkg;

  localparam int unsigned REP_LIMIT_DEFAULT = 32;
  localparam int unsigned BYTE_W            = 8;

  // Von Neumann pair phase encoding
  localparam logic [0:0] WAIT_FIRST = 1'b0;
  localparam logic [0:0] HAVE_FIRST = 1'b1;

endpackage

// File: rtl/trng_postproc_if.sv
// Byte output valid/ready bus between the conditioner and the I/O wrapper.
interface trng_postproc_if;
  import trng_pkg::*;

  logic [BYTE_W-1:0] byte_out;
  logic              byte_valid;
  logic              byte_ready;

  modport master (output byte_out, output byte_valid, input byte_ready);
  modport slave  (input byte_out, input byte_valid, output byte_ready);

endinterface

// File: rtl/trng_postproc_vn_debias.sv
// Von Neumann pair FSM: consumes raw bits in pairs, emits b0 when the pair differs.
module vn_debias
  import trng_pkg::*;
(
  input  logic CLK,
  input  logic RSTn,
  input  logic clr,
  input  logic in_valid,
  input  logic in_bit,
  output logic out_valid,
  output logic out_bit
);

  logic [0:0] state, state_n;
  logic       b0, b0_n;

  // State and first-bit register
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state <= WAIT_FIRST;
      b0    <= 1'b0;
    end else begin
      state <= state_n;
      b0    <= b0_n;
    end
  end

  // Next state; the debiased bit is presented in the same cycle as the second bit
  always_comb begin
    state_n   = state;
    b0_n      = b0;
    out_valid = 1'b0;
    out_bit   = 1'b0;
    if (clr) begin
      state_n = WAIT_FIRST;
    end else if (in_valid) begin
      case (state)
        WAIT_FIRST: begin
          b0_n    = in_bit;
          state_n = HAVE_FIRST;
        end
        default: begin
          out_valid = (b0 != in_bit);
          out_bit   = b0;
          state_n   = WAIT_FIRST;
        end
      endcase
    end
  end

endmodule

// File: rtl/trng_postproc.sv
// Entropy conditioner: repetition-count health test, von Neumann debias, byte packer.
module trng_postproc
  import trng_pkg::*;
#(
  parameter int unsigned REP_LIMIT = REP_LIMIT_DEFAULT
) (
  input  logic                    CLK,
  input  logic                    RSTn,
  input  logic                    en,
  input  logic                    raw_bit,
  input  logic                    raw_valid,
  trng_postproc_if.master         bus,
  output logic                    health_fail,
  output logic                    overflow
);

  localparam int unsigned RW = $clog2(REP_LIMIT + 1);
  localparam int unsigned CW = $clog2(BYTE_W);

  logic              accept_c;
  logic              trip_c;
  logic [RW-1:0]     run, run_n;
  logic              last_bit;
  logic              d_valid, d_bit;
  logic [CW-1:0]     cnt;
  logic [BYTE_W-2:0] sh;
  logic              complete_c;

  assign accept_c = raw_valid && en && !health_fail;

  // Run length after this cycle's accepted bit; run==0 marks "no bit seen since flush"
  always_comb begin
    run_n = run;
    if (accept_c) begin
      if (run == '0 || raw_bit != last_bit) begin
        run_n = RW'(1);
      end else if (run != RW'(REP_LIMIT)) begin
        run_n = run + RW'(1);
      end
    end
  end

  assign trip_c = accept_c && (run_n == RW'(REP_LIMIT));

  vn_debias u_vn (
    .CLK       (CLK),
    .RSTn      (RSTn),
    .clr       (!en),
    .in_valid  (accept_c && !trip_c),
    .in_bit    (raw_bit),
    .out_valid (d_valid),
    .out_bit   (d_bit)
  );

  assign complete_c = d_valid && (cnt == CW'(BYTE_W - 1));

  // Health counter, shift register and bit count; en low flushes partial state
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      run         <= '0;
      last_bit    <= 1'b0;
      cnt         <= '0;
      sh          <= '0;
      health_fail <= 1'b0;
    end else begin
      if (trip_c) health_fail <= 1'b1;
      if (!en) begin
        run <= '0;
        cnt <= '0;
        sh  <= '0;
      end else begin
        run <= run_n;
        if (accept_c) last_bit <= raw_bit;
        if (d_valid) begin
          sh  <= {sh[BYTE_W-3:0], d_bit};
          cnt <= (cnt == CW'(BYTE_W - 1)) ? '0 : cnt + CW'(1);
        end
      end
    end
  end

  // Output register and handshake; a byte completing into a held slot is dropped
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      bus.byte_out   <= '0;
      bus.byte_valid <= 1'b0;
      overflow       <= 1'b0;
    end else begin
      if (complete_c) begin
        if (bus.byte_valid && !bus.byte_ready) begin
          overflow <= 1'b1;
        end else begin
          bus.byte_out   <= {sh, d_bit};
          bus.byte_valid <= 1'b1;
        end
      end else if (bus.byte_valid && bus.byte_ready) begin
        bus.byte_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_trng_postproc.sv
// Directed bench for trng_postproc with a queue-based output scoreboard.
module tb_trng_postproc;

  logic CLK = 1'b0;
  logic RSTn;
  logic en;
  logic raw_bit;
  logic raw_valid;
  logic health_fail;
  logic overflow;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];

  trng_postproc_if bus ();

  trng_postproc #(.REP_LIMIT(32)) dut (
    .CLK         (CLK),
    .RSTn        (RSTn),
    .en          (en),
    .raw_bit     (raw_bit),
    .raw_valid   (raw_valid),
    .bus         (bus),
    .health_fail (health_fail),
    .overflow    (overflow)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every accepted transfer must match the oldest expected byte
  always @(negedge CLK) begin
    if (RSTn === 1'b1 && bus.byte_valid === 1'b1 && bus.byte_ready === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_byte: got %h expected none", bus.byte_out);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (bus.byte_out !== e) begin
          n_fail++;
          $display("FAIL byte_out: got %h expected %h", bus.byte_out, e);
        end
      end
    end
  end

  task automatic send_bit(input logic b);
    raw_bit   = b;
    raw_valid = 1'b1;
    @(posedge CLK); #1;
    raw_valid = 1'b0;
  endtask

  // Each byte bit MSB-first encoded as pair {b, ~b} so it debiases to b
  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) begin
      send_bit(v[i]);
      send_bit(~v[i]);
    end
  endtask

  task automatic apply_reset();
    raw_valid = 1'b0;
    raw_bit   = 1'b0;
    RSTn      = 1'b0;
    @(posedge CLK); #1;
    RSTn      = 1'b1;
  endtask

  initial begin
    logic [23:0] discard_bits;
    logic [7:0]  v;
    en             = 1'b0;
    bus.byte_ready = 1'b0;
    apply_reset();

    // Reset state
    @(negedge CLK);
    check("rst_valid", {7'b0, bus.byte_valid}, 8'h00);
    check("rst_byte", bus.byte_out, 8'h00);
    check("rst_health", {7'b0, health_fail}, 8'h00);
    check("rst_ovf", {7'b0, overflow}, 8'h00);

    // Basic packing, valid for exactly one cycle with ready high
    @(posedge CLK); #1;
    en = 1'b1;
    bus.byte_ready = 1'b1;
    exp_q.push_back(8'hA5);
    send_byte(8'hA5);
    @(negedge CLK);
    check("basic_valid_first", {7'b0, bus.byte_valid}, 8'h01);
    @(negedge CLK);
    check("basic_valid_drop", {7'b0, bus.byte_valid}, 8'h00);

    // Discarded pairs 00/11 skipped
    @(posedge CLK); #1;
    discard_bits = 24'b00_11_10_00_01_11_01_10_10_01_10_01;
    exp_q.push_back(8'h9A);
    for (int i = 23; i >= 0; i--) send_bit(discard_bits[i]);
    repeat (3) @(negedge CLK);

    // Repetition test: 31 ones stay healthy, 32 zeros trip
    apply_reset();
    en = 1'b1;
    for (int i = 0; i < 31; i++) send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    @(negedge CLK);
    check("rep31_no_fail", {7'b0, health_fail}, 8'h00);
    @(posedge CLK); #1;
    for (int i = 0; i < 31; i++) send_bit(1'b0);
    @(negedge CLK);
    check("rep_31zeros", {7'b0, health_fail}, 8'h00);
    @(posedge CLK); #1;
    send_bit(1'b0);
    @(negedge CLK);
    check("rep_32zeros", {7'b0, health_fail}, 8'h01);
    @(posedge CLK); #1;
    for (int i = 0; i < 64; i++) send_bit(i[0]);
    repeat (2) @(negedge CLK);
    check("rep_sticky", {7'b0, health_fail}, 8'h01);
    check("rep_no_bytes", {7'b0, bus.byte_valid}, 8'h00);

    // Backpressure: second byte dropped, first held
    apply_reset();
    en = 1'b1;
    bus.byte_ready = 1'b0;
    exp_q.push_back(8'hA5);
    send_byte(8'hA5);
    send_byte(8'h3C);
    @(negedge CLK);
    check("bp_byte_held", bus.byte_out, 8'hA5);
    check("bp_overflow", {7'b0, overflow}, 8'h01);
    @(posedge CLK); #1;
    bus.byte_ready = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    check("bp_valid_drop", {7'b0, bus.byte_valid}, 8'h00);

    // Flush: partial bits and a half pair discarded by one en-low cycle
    @(posedge CLK); #1;
    for (int i = 0; i < 5; i++) begin
      send_bit(1'b1);
      send_bit(1'b0);
    end
    send_bit(1'b1);
    en = 1'b0;
    @(posedge CLK); #1;
    en = 1'b1;
    exp_q.push_back(8'hF0);
    send_byte(8'hF0);
    repeat (2) @(negedge CLK);
    check("flush_ovf_sticky", {7'b0, overflow}, 8'h01);

    // Transfer and completion on the same edge: reload without overflow
    apply_reset();
    en = 1'b1;
    bus.byte_ready = 1'b0;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);
    send_byte(8'hA5);
    v = 8'h3C;
    for (int i = 7; i >= 1; i--) begin
      send_bit(v[i]);
      send_bit(~v[i]);
    end
    send_bit(v[0]);
    bus.byte_ready = 1'b1;
    send_bit(~v[0]);
    @(negedge CLK);
    check("reload_valid", {7'b0, bus.byte_valid}, 8'h01);
    check("reload_no_ovf", {7'b0, overflow}, 8'h00);
    @(negedge CLK);
    check("reload_drop", {7'b0, bus.byte_valid}, 8'h00);

    // Async reset with a held byte and health failure
    apply_reset();
    en = 1'b1;
    bus.byte_ready = 1'b0;
    send_byte(8'hA5);
    for (int i = 0; i < 32; i++) send_bit(1'b1);
    @(negedge CLK);
    check("ar_pre_valid", {7'b0, bus.byte_valid}, 8'h01);
    check("ar_pre_health", {7'b0, health_fail}, 8'h01);
    #2;
    RSTn = 1'b0;
    #1;
    check("ar_valid", {7'b0, bus.byte_valid}, 8'h00);
    check("ar_byte", bus.byte_out, 8'h00);
    check("ar_health", {7'b0, health_fail}, 8'h00);
    check("ar_ovf", {7'b0, overflow}, 8'h00);
    @(posedge CLK); #1;
    RSTn = 1'b1;
    bus.byte_ready = 1'b1;
    exp_q.push_back(8'h3C);
    send_byte(8'h3C);
    repeat (3) @(negedge CLK);

    check("queue_empty", 8'(exp_q.size()), 8'h00);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
